// File: rtl/seq_det_param.sv
// Serial pattern detector with loadable pattern, overlap control and a saturating match counter.
// Define SEQ_DET_CNT_EN to build the match counter; otherwise match_cnt is tied to zero.
module seq_det_param #(
    parameter int unsigned         PAT_W   = 4,
    parameter logic [PAT_W-1:0]    PAT_RST = 4'b1010,
    parameter int unsigned         CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i,
    input  logic                         in_valid,
    input  logic                         overlap,
    input  logic                         load,
    input  logic [PAT_W-1:0]             pat_in,
    input  logic                         clr_cnt,
    output logic                         out,
    output logic [$clog2(PAT_W+1)-1:0]   fill,
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  candidate;
    logic              full;
    logic              match;

    always_comb begin
        candidate = {hist_q, i};
        full      = (fill_q == FILL_W'(PAT_W - 1));
        match     = in_valid && !load && !rst && full && (candidate == pat_q);

        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;

        if (load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (in_valid) begin
            // A non-overlapping match consumes every history bit; otherwise keep sliding.
            if (match && !overlap) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = candidate[PAT_W-2:0];
                fill_d = full ? fill_q : fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PAT_RST;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
        end
    end

    assign out  = match;
    assign fill = fill_q;

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    logic cnt_unused;
    assign cnt_unused = clr_cnt;
    assign match_cnt  = '0;
`endif

endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 PAT_W, 4, pattern length in bits; legal range 2..16.
REQ-002 PAT_RST, 4'b1010 (PAT_W bits), pattern register value after reset.
REQ-003 CNT_W, 8, match-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 i  input  1  serial data bit.
REQ-007 in_valid  input  1  i is sampled only when high.
REQ-008 overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 load  input  1  load pat_in into pattern register.
REQ-010 pat_in  input  PAT_W  new pattern, MSB = first bit received.
REQ-011 clr_cnt  input  1  clear match counter.
REQ-012 out  output  1  Mealy match pulse, combinational, same cycle as final pattern bit.
REQ-013 fill  output  $clog2(PAT_W+1)  number of valid history bits held, saturating at PAT_W-1.
REQ-014 match_cnt  output  CNT_W  saturating count of matches.

Function
REQ-015 Block SHALL hold a PAT_W-1 bit history register hist (newest bit in LSB), a fill counter, a pattern register pat and a match counter.
REQ-016 On a cycle with in_valid=1, load=0, rst=0: candidate = {hist, i}; out SHALL be 1 iff fill == PAT_W-1 and candidate == pat.
REQ-017 out SHALL be 0 whenever in_valid=0, load=1 or rst=1.
REQ-018 Accepted bit with no match: hist SHALL shift left taking i into LSB; fill SHALL increment, saturating at PAT_W-1.
REQ-019 Accepted bit with match and overlap=1: hist shifts as in REQ-018; fill stays PAT_W-1 (trailing bits reusable).
REQ-020 Accepted bit with match and overlap=0: hist SHALL clear to 0 and fill SHALL become 0.
REQ-021 in_valid=0: hist and fill SHALL hold; gaps of any length SHALL not break a sequence.
REQ-022 load=1: pat <= pat_in, hist and fill SHALL clear to 0; any concurrent in_valid bit SHALL be discarded (load wins).
REQ-023 overlap MAY change any cycle; it SHALL affect only the match in that cycle.
REQ-024 match_cnt SHALL increment by 1 on each cycle with out=1, saturating at all-ones.
REQ-025 clr_cnt=1 SHALL set match_cnt to 0 next cycle, taking priority over a concurrent increment.
REQ-026 Priority order: rst > load > in_valid data path; clr_cnt independent of load.

Reset
REQ-027 On rising clk with rst=1: hist=0, fill=0, pat=PAT_RST, match_cnt=0.
REQ-028 Reset mid-sequence SHALL discard all partial progress; no match may complete using bits received before reset.
REQ-029 out SHALL be 0 during any cycle rst=1.

Configuration
REQ-030 Macro SEQ_DET_CNT_EN defined: match counter and clr_cnt behaviour per REQ-024/025 present.
REQ-031 SEQ_DET_CNT_EN undefined: counter logic SHALL not be built; match_cnt SHALL be constant 0; clr_cnt ignored; all other behaviour unchanged.

Verification
REQ-032 PAT_W=4, pat=1010, overlap=1, bits 1,0,1,0,1,0 valid each cycle -> out=1 on 4th and 6th bit only; match_cnt=2.
REQ-033 Same stream, overlap=0 -> out=1 on 4th bit only; fill=2 after 6th bit; match_cnt=1.
REQ-034 Bits 1,0,1 then rst for one cycle, then 0 -> out stays 0; fill=1 after the 0.
REQ-035 Bits 1,0 with 3 cycles in_valid=0 between them, then 1,0 -> out=1 on final 0 only.
REQ-036 load pat_in=0110 in same cycle as valid bit 1, then bits 0,1,1,0 -> load bit discarded, out=1 on final 0; earlier 1010 gives no match.
REQ-037 CNT_W=2, SEQ_DET_CNT_EN defined, 5 matches -> match_cnt=3; clr_cnt with concurrent match -> match_cnt=0.
